bcd_seq_conv: RTL and testbench
===============================

BCD_SEQ_CONV -- requirements
Module: bcd_seq_conv

Interface
REQ-001 Parameter NUMBIN, default 14, binary input width in bits (>=4).
REQ-002 Parameter NUMBCDS, default 4, number of BCD output digits (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  conversion request, sampled only in IDLE.
REQ-006 bin  input  NUMBIN  binary operand, captured in the cycle start is accepted.
REQ-007 busy  output  1  high while in CONVERT.
REQ-008 done  output  1  one-cycle pulse, result valid on bcd.
REQ-009 bcd  output  4*NUMBCDS  packed BCD result, digit 0 in bits [3:0].
REQ-010 overflow  output  1  operand exceeded 10^NUMBCDS-1 (see Configuration).

Function
REQ-011 FSM states SHALL be IDLE, CONVERT and DONE, with no others reachable.
REQ-012 IDLE with start=1 -> CONVERT; bin SHALL be latched into an internal shift register, BCD scratch cleared, and iteration counter loaded with NUMBIN.
REQ-013 IDLE with start=0 -> stay in IDLE; bcd and overflow SHALL hold.
REQ-014 Each CONVERT cycle: every scratch digit >=5 +3, then scratch||operand shift left 1; counter decrements.
REQ-015 CONVERT SHALL last exactly NUMBIN cycles, then -> DONE.
REQ-016 DONE: bcd register loaded from scratch, done=1 for exactly that cycle, then -> IDLE unconditionally.
REQ-017 Latency: start sampled on edge N -> done=1 during cycle N+NUMBIN+1; updated bcd visible in same cycle.
REQ-018 start while in CONVERT or DONE SHALL be ignored (no restart, no queueing); bin changes after capture SHALL not affect the result.
REQ-019 Back-to-back: start held high SHALL begin a new conversion on the first IDLE cycle after DONE.
REQ-020 Scratch SHALL be 4*NUMBCDS bits; bits shifted out of the top digit are discarded (truncation mod 10^NUMBCDS).
REQ-021 bcd and overflow SHALL hold their values from DONE until the next DONE.
REQ-022 busy SHALL be 0 in IDLE and DONE; done SHALL be 0 outside DONE.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, bcd=0, overflow=0, counter=0, scratch=0.
REQ-024 rst SHALL take priority over start and over any in-progress conversion; an aborted conversion SHALL produce no done pulse.
REQ-025 The first cycle after rst deasserts SHALL be IDLE and accept start.

Configuration
REQ-026 Macro BCD_OVERFLOW_SAT_EN SHALL control overflow handling.
REQ-027 Defined: at capture, bin > 10^NUMBCDS-1 SHALL be flagged; in DONE, bcd SHALL be all digits 9 and overflow=1; otherwise overflow=0.
REQ-028 Undefined: overflow SHALL be constant 0 and bcd SHALL be the truncated result per REQ-020.
REQ-029 Latency and handshake SHALL be identical in both builds.

Verification (NUMBCDS=4, NUMBIN=14)
REQ-030 rst, start with bin=0 -> done 15 cycles after start edge, bcd=16'h0000, overflow=0.
REQ-031 bin=10, then bin=255, then bin=9999 with start held high -> successive done pulses with bcd=0010, 0255, 9999, each 16 cycles apart.
REQ-032 bin=16383 -> with BCD_OVERFLOW_SAT_EN: bcd=9999, overflow=1; without: bcd=6383, overflow=0.
REQ-033 bin=1234 start, pulse start with bin=42 at iteration 5 -> single done, bcd=1234, busy high 14 cycles.
REQ-034 bin=9999 start, rst at iteration 7 -> no done pulse, bcd=0000, IDLE next cycle; new start bin=77 -> bcd=0077.
REQ-035 Exhaustive sweep bin 0..9999 back-to-back -> every bcd matches the decimal digits of bin, overflow=0.

Source files
------------

// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - sequential double-dabble binary-to-BCD converter, one bit per cycle
// Optional saturation on out-of-range operands: define BCD_OVERFLOW_SAT_EN
module bcd_seq_conv #(
  parameter int NUMBIN  = 14,
  parameter int NUMBCDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUMBIN-1:0]      bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NUMBCDS-1:0]   bcd,
  output logic                   overflow
);

  localparam int CW = $clog2(NUMBIN + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [NUMBIN-1:0]      r_sr;
  logic [4*NUMBCDS-1:0]   r_scratch;
  logic [4*NUMBCDS-1:0]   r_bcd;
  logic [CW-1:0]          r_cnt;
  logic [4*NUMBCDS-1:0]   w_adj;
  logic [4*NUMBCDS-1:0]   w_scratch_next;
  logic                   w_last;

`ifdef BCD_OVERFLOW_SAT_EN
  localparam logic [63:0] MAXVAL = 64'(10 ** NUMBCDS - 1);
  logic r_ovf_pend;
  logic r_ovf;
  assign overflow = r_ovf;
`else
  assign overflow = 1'b0;
`endif

  assign bcd    = r_bcd;
  assign w_last = (r_cnt == CW'(1));

  // Add-3 correction, then shift the operand MSB into the scratch LSB; top digit carry is dropped.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < NUMBCDS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
    w_scratch_next = {w_adj[4*NUMBCDS-2:0], r_sr[NUMBIN-1]};
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_CONVERT;
      end
      S_CONVERT: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
`ifdef BCD_OVERFLOW_SAT_EN
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr      <= bin;
            r_scratch <= '0;
            r_cnt     <= CW'(NUMBIN);
`ifdef BCD_OVERFLOW_SAT_EN
            r_ovf_pend <= (64'(bin) > MAXVAL);
`endif
          end
        end
        S_CONVERT: begin
          r_scratch <= w_scratch_next;
          r_sr      <= r_sr << 1;
          r_cnt     <= r_cnt - CW'(1);
          // Result register is loaded on the final shift so it is already valid while done is high.
          if (w_last) begin
`ifdef BCD_OVERFLOW_SAT_EN
            r_bcd <= r_ovf_pend ? {NUMBCDS{4'h9}} : w_scratch_next;
            r_ovf <= r_ovf_pend;
`else
            r_bcd <= w_scratch_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb/tb_bcd_seq_conv.sv - directed self-checking bench for bcd_seq_conv (NUMBIN=14, NUMBCDS=4)
// Expectations follow BCD_OVERFLOW_SAT_EN when it is defined for the build.
module tb_bcd_seq_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_seq_conv #(.NUMBIN(14), .NUMBCDS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at a negedge after DONE has passed.
  task automatic conv(input logic [13:0] b, output logic [15:0] obcd, output logic oovf,
                      output int lat, output int nbusy);
    obcd  = '0;
    oovf  = 1'b0;
    lat   = -1;
    nbusy = 0;
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = 14'($urandom);
    for (int k = 0; k < 40 && lat < 0; k++) begin
      if (busy) nbusy++;
      if (done) begin
        lat  = k;
        obcd = bcd;
        oovf = overflow;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  logic [15:0] r_bcd_got;
  logic        r_ovf_got;
  int          lat, nbusy, ndone, idx, nb, last_c;
  logic        prev_busy;
  logic [15:0] exp_b2b [3];

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Zero operand: done appears after 14 shift cycles, result 0000.
    conv(14'd0, r_bcd_got, r_ovf_got, lat, nbusy);
    check("zero_lat", 32'(lat), 32'd14);
    check("zero_busy", 32'(nbusy), 32'd14);
    check("zero_bcd", 32'(r_bcd_got), 32'h0000);
    check("zero_ovf", 32'(r_ovf_got), 32'd0);
    check("done_pulse_one", 32'(done), 32'd0);

    // Back-to-back with start held: 10, 255, 9999, done pulses 16 cycles apart.
    exp_b2b[0] = 16'h0010;
    exp_b2b[1] = 16'h0255;
    exp_b2b[2] = 16'h9999;
    start = 1'b1;
    bin   = 14'd10;
    idx = 0; nb = 0; last_c = -1; prev_busy = 1'b0;
    for (int c = 0; c < 80 && idx < 3; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        nb++;
        if (nb == 1) bin = 14'd255;
        else if (nb == 2) bin = 14'd9999;
        else start = 1'b0;
      end
      if (done) begin
        check("b2b_bcd", 32'(bcd), 32'(exp_b2b[idx]));
        check("b2b_busy_in_done", 32'(busy), 32'd0);
        if (idx > 0) check("b2b_gap", 32'(c - last_c), 32'd16);
        last_c = c;
        idx++;
      end
      prev_busy = busy;
    end
    check("b2b_count", 32'(idx), 32'd3);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Out-of-range operand: saturate or truncate depending on build.
    conv(14'd16383, r_bcd_got, r_ovf_got, lat, nbusy);
    check("ovf_lat", 32'(lat), 32'd14);
`ifdef BCD_OVERFLOW_SAT_EN
    check("ovf_bcd", 32'(r_bcd_got), 32'h9999);
    check("ovf_flag", 32'(r_ovf_got), 32'd1);
`else
    check("ovf_bcd", 32'(r_bcd_got), 32'h6383);
    check("ovf_flag", 32'(r_ovf_got), 32'd0);
`endif
    conv(14'd5, r_bcd_got, r_ovf_got, lat, nbusy);
    check("after_ovf_bcd", 32'(r_bcd_got), 32'h0005);
    check("after_ovf_flag", 32'(r_ovf_got), 32'd0);
    repeat (5) @(negedge clk);
    check("hold_bcd", 32'(bcd), 32'h0005);

    // Start pulse mid-conversion is ignored.
    start = 1'b1;
    bin   = 14'd1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 0; r_bcd_got = '0;
    for (int c = 0; c < 40; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        r_bcd_got = bcd;
      end
      if (c == 5) begin
        start = 1'b1;
        bin   = 14'd42;
      end
      if (c == 6) start = 1'b0;
      @(negedge clk);
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_bcd", 32'(r_bcd_got), 32'h1234);
    check("ign_busy", 32'(nbusy), 32'd14);

    // Reset mid-conversion aborts with no done pulse.
    start = 1'b1;
    bin   = 14'd9999;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) ndone++;
      if (c == 7) rst = 1'b1;
      if (c == 8) begin
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'h0000);
        rst = 1'b0;
      end
      @(negedge clk);
    end
    check("abort_ndone", 32'(ndone), 32'd0);
    conv(14'd77, r_bcd_got, r_ovf_got, lat, nbusy);
    check("post_rst_bcd", 32'(r_bcd_got), 32'h0077);
    check("post_rst_lat", 32'(lat), 32'd14);

    // Sparse sweep across the in-range operand space, including both ends.
    for (int i = 0; i <= 104; i++) begin
      int v;
      v = (i == 104) ? 9999 : i * 97;
      conv(14'(v), r_bcd_got, r_ovf_got, lat, nbusy);
      check($sformatf("sweep_bcd_%0d", v), 32'(r_bcd_got), 32'(to_bcd(v)));
      check($sformatf("sweep_ovf_%0d", v), 32'(r_ovf_got), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
